// File: rtl/sreg_rotator8.sv
// Parallel-load rotator register: load, rotate right/left by one bit, or hold.
// Latency: one clock from sampling edge to Q; no combinational input->Q path.
// Backpressure: none; accepts one operation every cycle.
module sreg_rotator8 #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             load,
    input  logic [1:0]       en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_nxt;

    // Load beats any rotate; unknown or both-set rotate controls fall to hold.
    always_comb begin
        q_nxt = q_reg;
        if (load) begin
            q_nxt = D;
        end else begin
            case (en)
                2'b01:   q_nxt = {q_reg[0], q_reg[WIDTH-1:1]};
                2'b10:   q_nxt = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                default: q_nxt = q_reg;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_nxt;
        end
    end

    assign Q = q_reg;

endmodule

// File: tb/tb_sreg_rotator8.sv
// Scoreboard bench for sreg_rotator8: expectations queued at drive time, popped after each edge.
module tb_sreg_rotator8;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       load;
    logic [1:0] en;
    logic [7:0] D;
    logic [7:0] Q;

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic [7:0] model;
    int         pass_cnt;
    int         total_cnt;

    sreg_rotator8 #(.WIDTH(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load),
        .en        (en),
        .D         (D),
        .Q         (Q)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    // Reference next-state built with shifts rather than concatenation.
    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic l,
                                            input logic [1:0] e, input logic [7:0] d);
        if (l)           return d;
        if (e == 2'b01)  return (cur >> 1) | (cur << 7);
        if (e == 2'b10)  return (cur << 1) | (cur >> 7);
        return cur;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        load = 1'b1;
        en = 2'b01;
        D = 8'h6D;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h00);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (Q !== exp_v) $display("FAIL reset_hold[%0d]: Q=%h expected %h", i, Q, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_priority();
        sys_rst_n = 1'b1;
        load = 1'b1;
        en = 2'b01;
        D = 8'b0110_1101;
        exp_q.push_back(8'h6D);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (Q !== exp_v) $display("FAIL load_priority: Q=%h expected %h", Q, exp_v);
        else pass_cnt++;
        model = 8'h6D;
    endtask

    task automatic test_rotate_right();
        logic [7:0] seq [5] = '{8'hB6, 8'h5B, 8'hAD, 8'hD6, 8'h6B};
        load = 1'b0;
        en = 2'b01;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(seq[i]);
            D = 8'($urandom);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (Q !== exp_v) $display("FAIL rotate_right[%0d]: Q=%h expected %h", i, Q, exp_v);
            else pass_cnt++;
        end
        model = 8'h6B;
    endtask

    task automatic test_rotate_left();
        logic [7:0] seq [5] = '{8'hD6, 8'hAD, 8'h5B, 8'hB6, 8'h6D};
        load = 1'b0;
        en = 2'b10;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(seq[i]);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (Q !== exp_v) $display("FAIL rotate_left[%0d]: Q=%h expected %h", i, Q, exp_v);
            else pass_cnt++;
        end
        model = 8'h6D;
    endtask

    task automatic test_hold();
        logic [1:0] modes [2] = '{2'b11, 2'b00};
        load = 1'b0;
        for (int m = 0; m < 2; m++) begin
            en = modes[m];
            for (int i = 0; i < 4; i++) begin
                D = (i % 2 == 0) ? 8'hFF : 8'h00;
                exp_q.push_back(8'h6D);
                tick();
                exp_v = exp_q.pop_front();
                total_cnt++;
                if (Q !== exp_v) $display("FAIL hold_en%b[%0d]: Q=%h expected %h", modes[m], i, Q, exp_v);
                else pass_cnt++;
            end
        end
        // Full-circle left rotation from a pattern with both end bits set.
        load = 1'b1;
        en = 2'b10;
        D = 8'h81;
        exp_q.push_back(8'h81);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (Q !== exp_v) $display("FAIL load_81: Q=%h expected %h", Q, exp_v);
        else pass_cnt++;
        load = 1'b0;
        model = 8'h81;
        for (int i = 0; i < 8; i++) begin
            model = ref_next(model, 1'b0, 2'b10, D);
            exp_q.push_back(i == 0 ? 8'h03 : (i == 7 ? 8'h81 : model));
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (Q !== exp_v) $display("FAIL rotl_circle[%0d]: Q=%h expected %h", i, Q, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic       l;
        logic [1:0] e;
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            l = ($urandom_range(0, 5) == 0);
            e = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            load = l;
            en = e;
            D = d;
            model = ref_next(model, l, e, d);
            exp_q.push_back(model);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (Q !== exp_v) $display("FAIL back_to_back[%0d] load=%b en=%b: Q=%h expected %h", i, l, e, Q, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1;
        en = 2'b00;
        D = 8'hA5;
        tick();
        load = 1'b0;
        en = 2'b01;
        #3;
        sys_rst_n = 1'b0;
        #1;
        exp_q.push_back(8'h00);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (Q !== exp_v) $display("FAIL async_reset_midcycle: Q=%h expected %h", Q, exp_v);
        else pass_cnt++;
        exp_q.push_back(8'h00);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (Q !== exp_v) $display("FAIL async_reset_held: Q=%h expected %h", Q, exp_v);
        else pass_cnt++;
        sys_rst_n = 1'b1;
        en = 2'b10;
        exp_q.push_back(8'h00);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (Q !== exp_v) $display("FAIL post_reset_rotate_zero: Q=%h expected %h", Q, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        model = 8'h00;
        test_reset();
        test_load_priority();
        test_rotate_right();
        test_rotate_left();
        test_hold();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
